// File: rtl/spi_init_pkg.sv
// Shared encodings for the table-driven SPI init sequencer.
// Step opcodes, sequencer states and a busy-state helper.
package spi_init_pkg;

   typedef enum logic [1:0] {
      OP_END        = 2'd0,
      OP_WRITE      = 2'd1,
      OP_READ_CHECK = 2'd2,
      OP_DELAY      = 2'd3
   } stepOp_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_TX,
      ST_WAIT_RX,
      ST_DELAY,
      ST_NEXT,
      ST_MISMATCH,
      ST_RETRY_WAIT,
      ST_DONE,
      ST_FAIL,
      ST_CMD_WAIT
   } seqState_t;

   function automatic logic isBusy(input seqState_t s);
      return !(s inside {ST_IDLE, ST_DONE, ST_FAIL});
   endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter that parks at zero.
// Shared by step delays, retry spacing and the SPI watchdog.
module seq_down_counter #(
   parameter int W = 32
) (
   input  logic         i_clock,
   input  logic         i_resetN,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   input  logic         i_enable,
   output logic         o_zero
);

   logic [W-1:0] count;

   always_ff @(posedge i_clock or negedge i_resetN) begin
      if (!i_resetN) begin
         count <= '0;
      end else if (i_load) begin
         count <= i_value;
      end else if (i_enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign o_zero = (count == '0);

endmodule

// File: rtl/spi_init_sequencer.sv
// Table-driven SPI bring-up sequencer with whole-sequence retry.
// Define SPI_INIT_SEQ_TIMEOUT_EN to add a watchdog on SPI done pulses.
module spi_init_sequencer
   import spi_init_pkg::*;
#(
   parameter int NUM_STEPS      = 16,
   parameter int ADDR_W         = 7,
   parameter int DATA_W         = 8,
   parameter int DELAY_W        = 32,
   parameter int MAX_RETRIES    = 3,
   parameter int RETRY_DELAY    = 50000000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                             i_clock,
   input  logic                             i_resetN,
   input  logic                             i_start,
   input  logic                             i_cmdValid,
   input  logic [ADDR_W-1:0]                i_cmdAddr,
   input  logic [DATA_W-1:0]                i_cmdData,
   output logic                             o_cmdReady,
   output logic [$clog2(NUM_STEPS)-1:0]     o_stepIndex,
   input  logic [1:0]                       i_stepOp,
   input  logic [ADDR_W-1:0]                i_stepAddr,
   input  logic [DATA_W-1:0]                i_stepData,
   input  logic [DELAY_W-1:0]               i_stepDelay,
   output logic                             o_spiTxBegin,
   output logic [ADDR_W-1:0]                o_spiTxAddress,
   output logic [DATA_W-1:0]                o_spiTxData,
   input  logic                             i_spiTxDone,
   output logic                             o_spiRxBegin,
   output logic [ADDR_W-1:0]                o_spiRxAddress,
   input  logic [DATA_W-1:0]                i_spiRxData,
   input  logic                             i_spiRxDone,
   output logic                             o_busy,
   output logic                             o_done,
   output logic                             o_fail,
   output logic [$clog2(MAX_RETRIES+1)-1:0] o_retryCount
);

   localparam int IDX_W = $clog2(NUM_STEPS);
   localparam int RC_W  = $clog2(MAX_RETRIES + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);
   localparam logic [RC_W-1:0]  RETRY_MAX = RC_W'(MAX_RETRIES);
   // Loaded one below so the wait state lasts exactly RETRY_DELAY cycles.
   localparam logic [DELAY_W-1:0] RETRY_LOAD =
      DELAY_W'((RETRY_DELAY > 0) ? RETRY_DELAY - 1 : 0);

`ifdef SPI_INIT_SEQ_TIMEOUT_EN
   localparam logic [DELAY_W-1:0] WD_LOAD =
      DELAY_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
`else
   logic unusedTimeout;
   assign unusedTimeout = ^TIMEOUT_CYCLES;
`endif

   seqState_t         state;
   stepOp_t           stepOp;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] expData;
   logic [RC_W-1:0]   retryCnt;
   logic              failQ;
   logic              txBegin;
   logic              rxBegin;
   logic [ADDR_W-1:0] txAddr;
   logic [DATA_W-1:0] txData;
   logic [ADDR_W-1:0] rxAddr;

   logic               cntLoad;
   logic [DELAY_W-1:0] cntValue;
   logic               cntEnable;
   logic               cntZero;

   assign stepOp = stepOp_t'(i_stepOp);

   always_comb begin
      cntLoad   = 1'b0;
      cntValue  = '0;
      cntEnable = 1'b0;
      unique case (state)
         ST_FETCH: begin
            if (stepOp == OP_DELAY) begin
               cntLoad  = 1'b1;
               cntValue = i_stepDelay;
            end
`ifdef SPI_INIT_SEQ_TIMEOUT_EN
            if (stepOp inside {OP_WRITE, OP_READ_CHECK}) begin
               cntLoad  = 1'b1;
               cntValue = WD_LOAD;
            end
`endif
         end
`ifdef SPI_INIT_SEQ_TIMEOUT_EN
         ST_IDLE: begin
            if (!i_start && i_cmdValid) begin
               cntLoad  = 1'b1;
               cntValue = WD_LOAD;
            end
         end
         ST_WAIT_TX, ST_WAIT_RX, ST_CMD_WAIT: cntEnable = 1'b1;
`endif
         ST_DELAY:      cntEnable = 1'b1;
         ST_RETRY_WAIT: cntEnable = 1'b1;
         ST_MISMATCH: begin
            cntLoad  = 1'b1;
            cntValue = RETRY_LOAD;
         end
         default: ;
      endcase
   end

   seq_down_counter #(
      .W(DELAY_W)
   ) u_counter (
      .i_clock (i_clock),
      .i_resetN(i_resetN),
      .i_load  (cntLoad),
      .i_value (cntValue),
      .i_enable(cntEnable),
      .o_zero  (cntZero)
   );

   always_ff @(posedge i_clock or negedge i_resetN) begin
      if (!i_resetN) begin
         state    <= ST_IDLE;
         idx      <= '0;
         expData  <= '0;
         retryCnt <= '0;
         failQ    <= 1'b0;
         txBegin  <= 1'b0;
         rxBegin  <= 1'b0;
         txAddr   <= '0;
         txData   <= '0;
         rxAddr   <= '0;
      end else begin
         txBegin <= 1'b0;
         rxBegin <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (i_start) begin
                  failQ    <= 1'b0;
                  retryCnt <= '0;
                  idx      <= '0;
                  state    <= ST_FETCH;
               end else if (i_cmdValid) begin
                  txAddr  <= i_cmdAddr;
                  txData  <= i_cmdData;
                  txBegin <= 1'b1;
                  state   <= ST_CMD_WAIT;
               end
            end
            ST_FETCH: begin
               unique case (stepOp)
                  OP_WRITE: begin
                     txAddr  <= i_stepAddr;
                     txData  <= i_stepData;
                     txBegin <= 1'b1;
                     state   <= ST_WAIT_TX;
                  end
                  OP_READ_CHECK: begin
                     rxAddr  <= i_stepAddr;
                     expData <= i_stepData;
                     rxBegin <= 1'b1;
                     state   <= ST_WAIT_RX;
                  end
                  OP_DELAY: state <= ST_DELAY;
                  OP_END:   state <= ST_DONE;
               endcase
            end
            ST_WAIT_TX: begin
               if (i_spiTxDone) begin
                  state <= ST_NEXT;
`ifdef SPI_INIT_SEQ_TIMEOUT_EN
               end else if (cntZero) begin
                  state <= ST_MISMATCH;
`endif
               end
            end
            ST_WAIT_RX: begin
               if (i_spiRxDone) begin
                  state <= (i_spiRxData == expData) ? ST_NEXT : ST_MISMATCH;
`ifdef SPI_INIT_SEQ_TIMEOUT_EN
               end else if (cntZero) begin
                  state <= ST_MISMATCH;
`endif
               end
            end
            ST_DELAY: begin
               if (cntZero) state <= ST_NEXT;
            end
            ST_NEXT: begin
               // Running off the end of the table counts as END.
               if (idx == LAST_IDX) begin
                  state <= ST_DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= ST_FETCH;
               end
            end
            ST_MISMATCH: begin
               if (retryCnt == RETRY_MAX) begin
                  failQ <= 1'b1;
                  state <= ST_FAIL;
               end else begin
                  retryCnt <= retryCnt + 1'b1;
                  state    <= ST_RETRY_WAIT;
               end
            end
            ST_RETRY_WAIT: begin
               if (cntZero) begin
                  idx   <= '0;
                  state <= ST_FETCH;
               end
            end
            ST_DONE: state <= ST_IDLE;
            ST_FAIL: state <= ST_IDLE;
            ST_CMD_WAIT: begin
               if (i_spiTxDone) begin
                  state <= ST_DONE;
`ifdef SPI_INIT_SEQ_TIMEOUT_EN
               end else if (cntZero) begin
                  failQ <= 1'b1;
                  state <= ST_FAIL;
`endif
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_cmdReady     = (state == ST_IDLE);
   assign o_busy         = isBusy(state);
   assign o_done         = (state == ST_DONE);
   assign o_fail         = failQ;
   assign o_retryCount   = retryCnt;
   assign o_stepIndex    = idx;
   assign o_spiTxBegin   = txBegin;
   assign o_spiTxAddress = txAddr;
   assign o_spiTxData    = txData;
   assign o_spiRxBegin   = rxBegin;
   assign o_spiRxAddress = rxAddr;

endmodule

// File: tb/tb_spi_init_sequencer.sv
// Directed bench for spi_init_sequencer with a small SPI responder.
// Honours SPI_INIT_SEQ_TIMEOUT_EN for the watchdog scenario.
module tb_spi_init_sequencer;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       start = 1'b0;
   logic       cmdValid = 1'b0;
   logic [6:0] cmdAddr = '0;
   logic [7:0] cmdData = '0;
   logic       cmdReady;
   logic [3:0] stepIndex;
   logic [1:0] stepOp;
   logic [6:0] stepAddr;
   logic [7:0] stepData;
   logic [31:0] stepDelay;
   logic       txBegin;
   logic [6:0] txAddress;
   logic [7:0] txDataO;
   logic       spiTxDone = 1'b0;
   logic       rxBegin;
   logic [6:0] rxAddress;
   logic [7:0] spiRxData = '0;
   logic       spiRxDone = 1'b0;
   logic       busy;
   logic       done;
   logic       fail;
   logic [1:0] retryCount;

   logic [1:0]  tOp[16];
   logic [6:0]  tAddr[16];
   logic [7:0]  tData[16];
   logic [31:0] tDelay[16];

   assign stepOp    = tOp[stepIndex];
   assign stepAddr  = tAddr[stepIndex];
   assign stepData  = tData[stepIndex];
   assign stepDelay = tDelay[stepIndex];

   spi_init_sequencer #(
      .RETRY_DELAY(20),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .i_clock(clk),
      .i_resetN(resetN),
      .i_start(start),
      .i_cmdValid(cmdValid),
      .i_cmdAddr(cmdAddr),
      .i_cmdData(cmdData),
      .o_cmdReady(cmdReady),
      .o_stepIndex(stepIndex),
      .i_stepOp(stepOp),
      .i_stepAddr(stepAddr),
      .i_stepData(stepData),
      .i_stepDelay(stepDelay),
      .o_spiTxBegin(txBegin),
      .o_spiTxAddress(txAddress),
      .o_spiTxData(txDataO),
      .i_spiTxDone(spiTxDone),
      .o_spiRxBegin(rxBegin),
      .o_spiRxAddress(rxAddress),
      .i_spiRxData(spiRxData),
      .i_spiRxDone(spiRxDone),
      .o_busy(busy),
      .o_done(done),
      .o_fail(fail),
      .o_retryCount(retryCount)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // responder state and logs
   int txCnt = 0, rxCnt = 0, rxLatency = 3;
   logic holdTx = 1'b0;
   logic [7:0] rxValue = 8'h00;
   int txPulses = 0, rxPulses = 0, donePulses = 0;
   int txDoneCycle = 0, doneCycle = 0;
   int widthErr = 0, holdErr = 0;
   logic prevTxB = 1'b0, prevRxB = 1'b0;
   logic [6:0] lastTxAddr = '0, lastRxAddr = '0;
   logic [7:0] lastTxData = '0;
   logic [6:0] txAddrLog[8];
   logic [7:0] txDataLog[8];
   logic [6:0] rxAddrLog[8];
   int txBeginCyc[8];
   int rxBeginCyc[8];

   always @(negedge clk) begin
      cyc = cyc + 1;
      spiTxDone = 1'b0;
      spiRxDone = 1'b0;
      if (busy && txCnt > 0 &&
          (txAddress !== lastTxAddr || txDataO !== lastTxData))
         holdErr = holdErr + 1;
      if (busy && rxCnt > 0 && rxAddress !== lastRxAddr)
         holdErr = holdErr + 1;
      if (txCnt > 0) begin
         txCnt = txCnt - 1;
         if (txCnt == 0 && !holdTx) begin
            spiTxDone = 1'b1;
            txDoneCycle = cyc;
         end
      end
      if (rxCnt > 0) begin
         rxCnt = rxCnt - 1;
         if (rxCnt == 0) begin
            spiRxDone = 1'b1;
            spiRxData = rxValue;
         end
      end
      if (txBegin) begin
         if (txPulses < 8) begin
            txAddrLog[txPulses] = txAddress;
            txDataLog[txPulses] = txDataO;
            txBeginCyc[txPulses] = cyc;
         end
         txPulses = txPulses + 1;
         lastTxAddr = txAddress;
         lastTxData = txDataO;
         txCnt = 3;
      end
      if (rxBegin) begin
         if (rxPulses < 8) begin
            rxAddrLog[rxPulses] = rxAddress;
            rxBeginCyc[rxPulses] = cyc;
         end
         rxPulses = rxPulses + 1;
         lastRxAddr = rxAddress;
         rxCnt = rxLatency;
      end
      if (txBegin && prevTxB) widthErr = widthErr + 1;
      if (rxBegin && prevRxB) widthErr = widthErr + 1;
      prevTxB = txBegin;
      prevRxB = rxBegin;
      if (done) begin
         donePulses = donePulses + 1;
         doneCycle = cyc;
      end
   end

   task automatic clearTable();
      for (int i = 0; i < 16; i++) begin
         tOp[i] = 2'd0;
         tAddr[i] = '0;
         tData[i] = '0;
         tDelay[i] = '0;
      end
   endtask

   task automatic clearLogs();
      txPulses = 0;
      rxPulses = 0;
      donePulses = 0;
   endtask

   task automatic pulseStart();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (cmdReady !== 1'b1) begin
         bad++;
         $display("FAIL reset_cmdReady got=%0b want=1", cmdReady);
      end
      total++;
      if ({busy, done, fail, txBegin, rxBegin} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b want=00000",
                  {busy, done, fail, txBegin, rxBegin});
      end
      total++;
      if ({stepIndex, retryCount, txAddress, txDataO, rxAddress} !== '0) begin
         bad++;
         $display("FAIL reset_regs idx=%0d rc=%0d ta=%h td=%h ra=%h want=0",
                  stepIndex, retryCount, txAddress, txDataO, rxAddress);
      end
      resetN = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (cmdReady !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle ready=%0b busy=%0b want=1/0",
                  cmdReady, busy);
      end
   endtask

   task automatic test_write_delay();
      clearTable();
      tOp[0] = 2'd1; tAddr[0] = 7'h06; tData[0] = 8'h00;
      tOp[1] = 2'd1; tAddr[1] = 7'h08; tData[1] = 8'h30;
      tOp[2] = 2'd3; tDelay[2] = 32'd10;
      tOp[3] = 2'd0;
      clearLogs();
      pulseStart();
      for (int i = 0; i < 200 && donePulses == 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      total++;
      if (txPulses !== 2) begin
         bad++;
         $display("FAIL wr_tx_count got=%0d want=2", txPulses);
      end
      total++;
      if (txAddrLog[0] !== 7'h06 || txDataLog[0] !== 8'h00) begin
         bad++;
         $display("FAIL wr_step0 got=%h/%h want=06/00",
                  txAddrLog[0], txDataLog[0]);
      end
      total++;
      if (txAddrLog[1] !== 7'h08 || txDataLog[1] !== 8'h30) begin
         bad++;
         $display("FAIL wr_step1 got=%h/%h want=08/30",
                  txAddrLog[1], txDataLog[1]);
      end
      // NEXT, FETCH, 11 DELAY cycles, NEXT, FETCH, then DONE
      total++;
      if (doneCycle - txDoneCycle !== 16) begin
         bad++;
         $display("FAIL wr_delay_gap got=%0d want=16",
                  doneCycle - txDoneCycle);
      end
      total++;
      if (donePulses !== 1 || fail !== 1'b0) begin
         bad++;
         $display("FAIL wr_done done=%0d fail=%0b want=1/0",
                  donePulses, fail);
      end
   endtask

   task automatic test_read_pass();
      clearTable();
      tOp[0] = 2'd2; tAddr[0] = 7'h78; tData[0] = 8'h20;
      rxValue = 8'h20;
      clearLogs();
      pulseStart();
      for (int i = 0; i < 100 && donePulses == 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      total++;
      if (rxPulses !== 1 || rxAddrLog[0] !== 7'h78) begin
         bad++;
         $display("FAIL rd_pass_rx cnt=%0d addr=%h want=1/78",
                  rxPulses, rxAddrLog[0]);
      end
      total++;
      if (donePulses !== 1 || retryCount !== 2'd0 || fail !== 1'b0) begin
         bad++;
         $display("FAIL rd_pass_end done=%0d rc=%0d fail=%0b want=1/0/0",
                  donePulses, retryCount, fail);
      end
   endtask

   task automatic test_read_retry();
      clearTable();
      tOp[0] = 2'd2; tAddr[0] = 7'h78; tData[0] = 8'h20;
      rxValue = 8'h13;
      clearLogs();
      pulseStart();
      for (int i = 0; i < 400 && fail !== 1'b1; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      total++;
      if (rxPulses !== 4) begin
         bad++;
         $display("FAIL retry_rx_count got=%0d want=4", rxPulses);
      end
      // 3 rx latency, MISMATCH, 20 wait cycles, FETCH, then begin
      for (int k = 1; k < 4; k++) begin
         total++;
         if (rxBeginCyc[k] - rxBeginCyc[k-1] !== 26) begin
            bad++;
            $display("FAIL retry_gap%0d got=%0d want=26",
                     k, rxBeginCyc[k] - rxBeginCyc[k-1]);
         end
      end
      total++;
      if (fail !== 1'b1 || donePulses !== 0 || retryCount !== 2'd3) begin
         bad++;
         $display("FAIL retry_end fail=%0b done=%0d rc=%0d want=1/0/3",
                  fail, donePulses, retryCount);
      end
      total++;
      if (busy !== 1'b0 || cmdReady !== 1'b1) begin
         bad++;
         $display("FAIL retry_idle busy=%0b ready=%0b want=0/1",
                  busy, cmdReady);
      end
   endtask

   task automatic test_fail_clear();
      rxValue = 8'h20;
      clearLogs();
      pulseStart();
      total++;
      if (fail !== 1'b0 || retryCount !== 2'd0) begin
         bad++;
         $display("FAIL clear_on_start fail=%0b rc=%0d want=0/0",
                  fail, retryCount);
      end
      for (int i = 0; i < 100 && donePulses == 0; i++) @(negedge clk);
      total++;
      if (donePulses !== 1) begin
         bad++;
         $display("FAIL clear_rerun done=%0d want=1", donePulses);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_cmd();
      int seen;
      clearLogs();
      @(negedge clk);
      cmdAddr = 7'h01;
      cmdData = 8'h02;
      cmdValid = 1'b1;
      @(negedge clk);
      cmdValid = 1'b0;
      total++;
      if (cmdReady !== 1'b0 || txBegin !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL cmd_issue ready=%0b begin=%0b busy=%0b want=0/1/1",
                  cmdReady, txBegin, busy);
      end
      for (int i = 0; i < 50 && donePulses == 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      total++;
      if (txPulses !== 1 || txAddrLog[0] !== 7'h01 ||
          txDataLog[0] !== 8'h02 || donePulses !== 1) begin
         bad++;
         $display("FAIL cmd_single tx=%0d a=%h d=%h done=%0d want=1/01/02/1",
                  txPulses, txAddrLog[0], txDataLog[0], donePulses);
      end
      clearTable();
      tOp[0] = 2'd1; tAddr[0] = 7'h10; tData[0] = 8'h55;
      clearLogs();
      seen = 0;
      @(negedge clk);
      start = 1'b1;
      cmdValid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || stepIndex !== 4'd0) begin
         bad++;
         $display("FAIL start_wins busy=%0b idx=%0d want=1/0",
                  busy, stepIndex);
      end
      for (int i = 0; i < 100 && seen < 2; i++) begin
         @(negedge clk);
         if (txBegin) seen++;
      end
      cmdValid = 1'b0;
      for (int i = 0; i < 50 && donePulses < 2; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      total++;
      if (txAddrLog[0] !== 7'h10 || txDataLog[0] !== 8'h55) begin
         bad++;
         $display("FAIL both_first got=%h/%h want=10/55",
                  txAddrLog[0], txDataLog[0]);
      end
      total++;
      if (txPulses !== 2 || txAddrLog[1] !== 7'h01 ||
          txDataLog[1] !== 8'h02 || donePulses !== 2) begin
         bad++;
         $display("FAIL both_pending tx=%0d a=%h d=%h done=%0d want=2/01/02/2",
                  txPulses, txAddrLog[1], txDataLog[1], donePulses);
      end
   endtask

   task automatic test_reset_midflight();
      int rxSnap, doneSnap, txSnap;
      clearTable();
      tOp[0] = 2'd2; tAddr[0] = 7'h78; tData[0] = 8'h20;
      rxValue = 8'h20;
      rxLatency = 8;
      clearLogs();
      pulseStart();
      for (int i = 0; i < 20 && rxPulses == 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      resetN = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || cmdReady !== 1'b1) begin
         bad++;
         $display("FAIL async_reset busy=%0b ready=%0b want=0/1",
                  busy, cmdReady);
      end
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      rxSnap = rxPulses;
      txSnap = txPulses;
      doneSnap = donePulses;
      repeat (12) @(negedge clk);
      total++;
      if (busy !== 1'b0 || cmdReady !== 1'b1 || stepIndex !== 4'd0 ||
          fail !== 1'b0 || retryCount !== 2'd0 || rxAddress !== 7'h00) begin
         bad++;
         $display("FAIL late_done_state busy=%0b rdy=%0b idx=%0d fail=%0b rc=%0d ra=%h",
                  busy, cmdReady, stepIndex, fail, retryCount, rxAddress);
      end
      total++;
      if (rxPulses !== rxSnap || txPulses !== txSnap ||
          donePulses !== doneSnap) begin
         bad++;
         $display("FAIL late_done_activity rx=%0d tx=%0d done=%0d want=%0d/%0d/%0d",
                  rxPulses, txPulses, donePulses, rxSnap, txSnap, doneSnap);
      end
      rxLatency = 3;
   endtask

   task automatic test_timeout();
      clearTable();
      tOp[0] = 2'd1; tAddr[0] = 7'h20; tData[0] = 8'h01;
      holdTx = 1'b1;
      clearLogs();
      pulseStart();
`ifdef SPI_INIT_SEQ_TIMEOUT_EN
      for (int i = 0; i < 800 && fail !== 1'b1; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      // 100 watchdog cycles, MISMATCH, 20 wait cycles, FETCH
      total++;
      if (txBeginCyc[1] - txBeginCyc[0] !== 122) begin
         bad++;
         $display("FAIL wd_gap got=%0d want=122",
                  txBeginCyc[1] - txBeginCyc[0]);
      end
      total++;
      if (txPulses !== 4 || fail !== 1'b1 || retryCount !== 2'd3) begin
         bad++;
         $display("FAIL wd_fail tx=%0d fail=%0b rc=%0d want=4/1/3",
                  txPulses, fail, retryCount);
      end
`else
      repeat (300) @(negedge clk);
      total++;
      if (busy !== 1'b1 || txPulses !== 1 || fail !== 1'b0) begin
         bad++;
         $display("FAIL no_wd_stall busy=%0b tx=%0d fail=%0b want=1/1/0",
                  busy, txPulses, fail);
      end
      resetN = 1'b0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
`endif
      holdTx = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_pulse_integrity();
      total++;
      if (widthErr !== 0) begin
         bad++;
         $display("FAIL begin_width got=%0d want=0", widthErr);
      end
      total++;
      if (holdErr !== 0) begin
         bad++;
         $display("FAIL addr_hold got=%0d want=0", holdErr);
      end
   endtask

   initial begin
      clearTable();
      test_reset();
      test_write_delay();
      test_read_pass();
      test_read_retry();
      test_fail_clear();
      test_cmd();
      test_reset_midflight();
      test_timeout();
      test_pulse_integrity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_init_sequencer.md
Name: spi_init_sequencer

Overview:
Table-driven, parametrised successor to the fixed HDP bring-up controller. It walks a step table of up to NUM_STEPS entries, with these operations: SPI write, SPI read-and-compare, timed delay, and end. It retries the whole sequence on a compare mismatch and also accepts single-register command writes (activate/shutdown) when idle. It sits between the top-level control logic and the existing spi module; the step table is supplied externally as ROM or constants.

Parameters:
NUM_STEPS, 16, table depth; index width IDX_W = $clog2(NUM_STEPS)
ADDR_W, 7, SPI register address width
DATA_W, 8, SPI data width
DELAY_W, 32, delay field / counter width
MAX_RETRIES, 3, full-sequence retries after a compare mismatch before failing
RETRY_DELAY, 50000000, idle cycles between a mismatch and the restart
TIMEOUT_CYCLES, 1000000, SPI done watchdog (optional feature only)

Ports:
i_clock  in  1  system clock
i_resetN  in  1  asynchronous active-low reset
i_start  in  1  pulse: run the table from step 0
i_cmdValid  in  1  single-write command request
i_cmdAddr  in  ADDR_W  command address
i_cmdData  in  DATA_W  command data
o_cmdReady  out  1  high in IDLE only
o_stepIndex  out  IDX_W  table read index
i_stepOp  in  2  0=END 1=WRITE 2=READ_CHECK 3=DELAY
i_stepAddr  in  ADDR_W  step address
i_stepData  in  DATA_W  write data / expected read value
i_stepDelay  in  DELAY_W  DELAY cycle count
o_spiTxBegin  out  1  one-cycle pulse to spi
o_spiTxAddress  out  ADDR_W  spi tx address
o_spiTxData  out  DATA_W  spi tx data
i_spiTxDone  in  1  spi tx done pulse
o_spiRxBegin  out  1  one-cycle pulse to spi
o_spiRxAddress  out  ADDR_W  spi rx address
i_spiRxData  in  DATA_W  spi rx data
i_spiRxDone  in  1  spi rx done pulse
o_busy  out  1  high outside IDLE/DONE/FAIL
o_done  out  1  one-cycle pulse on success
o_fail  out  1  level; cleared by next i_start
o_retryCount  out  2+  retries consumed; width $clog2(MAX_RETRIES+1)

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 except o_cmdReady=1. Index, retry count and counters 0. In-flight SPI transactions are abandoned; a subsequent done pulse is ignored in IDLE.
- Table access: o_stepIndex is registered. Step fields are sampled in FETCH one cycle after the index updates, so a combinational ROM is required.
- IDLE: if i_start, clear o_fail and the retry count, set index 0, go to FETCH. Otherwise, if i_cmdValid, latch addr/data, pulse o_spiTxBegin and go to CMD_WAIT. i_start wins when both are asserted in the same cycle; the command is not consumed.
- FETCH: decode the op.
  - WRITE: pulse TxBegin, go to WAIT_TX.
  - READ_CHECK: pulse RxBegin, go to WAIT_RX.
  - DELAY: load the counter, go to DELAY. A count of 0 means one cycle.
  - END: go to DONE.
- WAIT_TX, on i_spiTxDone: go to NEXT.
- WAIT_RX, on i_spiRxDone: if i_spiRxData equals i_stepData latched at FETCH, go to NEXT; otherwise go to MISMATCH.
- DELAY: count down; at 0 go to NEXT.
- NEXT: increment the index and go to FETCH. If the index was NUM_STEPS-1, go to DONE (implicit END; no wrap).
- MISMATCH: if the retry count equals MAX_RETRIES, set o_fail and go to FAIL. Otherwise increment the count and go to RETRY_WAIT.
- RETRY_WAIT: wait RETRY_DELAY cycles, then set index 0 and go to FETCH.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- FAIL: go straight to IDLE; o_fail holds.
- CMD_WAIT, on i_spiTxDone: go to DONE (o_done pulses).
- Begin pulses are exactly one cycle wide. Address/data outputs are held stable until the matching done.
- i_start or i_cmdValid outside IDLE is ignored.

Optional Feature:
SPI_INIT_SEQ_TIMEOUT_EN
- Defined: WAIT_TX, WAIT_RX and CMD_WAIT run a watchdog. After TIMEOUT_CYCLES without a done pulse, the step is treated as a mismatch (same retry path). In CMD_WAIT, a timeout sets o_fail and returns to IDLE.
- Undefined: no watchdog; waits are unbounded.

Decomposition:
- Package spi_init_pkg: op encodings (OP_END/WRITE/READ_CHECK/DELAY) and the state enum.
- One sub-module, seq_down_counter, shared by DELAY, RETRY_WAIT and the watchdog. Ports: load, value, enable, zero flag.

Test Plan:
- Table {WRITE 0x06=0x00, WRITE 0x08=0x30, DELAY 10, END}, i_start -> two TxBegin pulses with matching addr/data, >=11 idle cycles after the second done, o_done one cycle, o_fail=0.
- READ_CHECK 0x78 expect 0x20, spi returns 0x20 -> sequence continues to END, o_retryCount=0.
- Same step, spi always returns 0x13, MAX_RETRIES=3, RETRY_DELAY=20 -> 4 RxBegin pulses spaced >=20 cycles, then o_fail=1, no o_done, o_retryCount=3.
- In IDLE, i_cmdValid with addr 0x01 / data 0x02 -> TxBegin with 0x01/0x02, o_done after TxDone. Assert i_start and i_cmdValid together -> sequence starts, command left pending.
- i_resetN low during WAIT_RX, late i_spiRxDone after release -> IDLE, all outputs 0, o_cmdReady=1, no state change.
- Timeout feature defined, TIMEOUT_CYCLES=100, TxDone withheld -> mismatch path taken at cycle 100. Feature undefined -> stays in WAIT_TX.
